// File: rtl/fix_ari_acc.sv
// rtl/fix_ari_acc.sv - saturating fixed-point frame accumulator with valid/ready handshakes
module fix_ari_acc #(
  parameter int DATA  = 16,
  parameter int LEN   = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [DATA-1:0] data_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DATA-1:0] data_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            sat_flag
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam logic [DATA-1:0]  VAL_MIN  = {1'b1, {(DATA-1){1'b0}}};
  localparam logic [DATA-1:0]  VAL_MAX  = {1'b0, {(DATA-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic [0:0]       state_q,     state_d;
  logic [DATA-1:0]  acc_q,       acc_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [DATA-1:0]  data_out_q,  data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_q,       sat_d;

  logic [DATA:0]    sum_mid;
  logic [DATA-1:0]  acc_next;
  logic             step_sat;
  logic             accept;

  // One extra bit of headroom: the sum overflowed exactly when the two top bits disagree,
  // and the extended sign bit tells which rail to clamp to.
  always_comb begin
    sum_mid  = {acc_q[DATA-1], acc_q} + {data_in[DATA-1], data_in};
    step_sat = sum_mid[DATA] ^ sum_mid[DATA-1];
    if (step_sat) begin
      acc_next = sum_mid[DATA] ? VAL_MIN : VAL_MAX;
    end else begin
      acc_next = sum_mid[DATA-1:0];
    end
  end

  // in_ready depends on state only, so there is no path from out_ready or in_valid.
  assign in_ready  = (state_q == ST_ACC);
  assign accept    = in_valid & in_ready;
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;

  // Next-state logic; clear overrides any accept or output handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    if (clear) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      sat_d       = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            acc_d = acc_next;
            sat_d = sat_q | step_sat;
            if (count_q == CNT_LAST) begin
              data_out_d  = acc_next;
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
              count_d     = '0;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        default: begin
          // Result held until taken; the handshake cycle never consumes a sample.
          if (out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            sat_d       = 1'b0;
            state_d     = ST_ACC;
          end
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

endmodule

// File: tb/tb_fix_ari_acc.sv
// tb/tb_fix_ari_acc.sv - self-checking bench for fix_ari_acc with a behavioural frame model
module tb_fix_ari_acc;

  localparam int DATA = 16;
  localparam int LEN  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic [DATA-1:0] data_in = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DATA-1:0] data_out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            sat_flag;

  int checks = 0;
  int errors = 0;

  fix_ari_acc #(.DATA(DATA), .LEN(LEN), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame model: integer running sum clamped to the signed range after every sample.
  function automatic void model4(input logic [15:0] a, b, c, d,
                                 output logic [15:0] res, output logic sat);
    int acc;
    logic [15:0] v[4];
    v = '{a, b, c, d};
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + int'($signed(v[i]));
      if (acc > 32767) begin
        acc = 32767;
        sat = 1'b1;
      end else if (acc < -32768) begin
        acc = -32768;
        sat = 1'b1;
      end
    end
    res = acc[15:0];
  endfunction

  task automatic send1(input logic [15:0] v);
    @(negedge clk);
    data_in  = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed4(input logic [15:0] a, b, c, d, input int gap);
    logic [15:0] v[4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      send1(v[i]);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          data_in = 16'($urandom);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 16'h0 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b data_out=%h sat=%b, expected 0/0000/0",
               out_valid, data_out, sat_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    feed4(16'd1, 16'd2, 16'd3, 16'd4, 0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'd10 || sat_flag !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: ov=%b data=%h sat=%b rdy=%b, expected 1/000a/0/0",
               out_valid, data_out, sat_flag, in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: ov=%b rdy=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturate(input logic [15:0] a, b, c, d, input string nm);
    logic [15:0] er;
    logic es;
    model4(a, b, c, d, er, es);
    feed4(a, b, c, d, 0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== er || sat_flag !== es) begin
      errors++;
      $display("FAIL %s: ov=%b data=%h sat=%b, expected 1/%h/%b",
               nm, out_valid, data_out, sat_flag, er, es);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [15:0] er;
    logic es;
    model4(16'h7000, 16'h7000, 16'h7000, 16'h7000, er, es);
    feed4(16'h7000, 16'h7000, 16'h7000, 16'h7000, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = 16'h0101;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== er || sat_flag !== es) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: rdy=%b ov=%b data=%h sat=%b, expected 0/1/%h/%b",
                 i, in_ready, out_valid, data_out, sat_flag, er, es);
      end
    end
    in_valid = 1'b0;
    handshake();
    feed4(16'd1, 16'd1, 16'd1, 16'd1, 0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'd4 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_next: ov=%b data=%h sat=%b, expected 1/0004/0",
               out_valid, data_out, sat_flag);
    end
    handshake();
  endtask

  task automatic test_gaps();
    send1(16'd5);
    repeat (2) @(posedge clk);
    send1(16'hFFFD);
    repeat (3) @(posedge clk);
    send1(16'd7);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL gaps_partial: ov=%b rdy=%b, expected 0/1", out_valid, in_ready);
    end
    send1(16'd1);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'd10 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL gaps_result: ov=%b data=%h sat=%b, expected 1/000a/0",
               out_valid, data_out, sat_flag);
    end
    handshake();
  endtask

  task automatic test_clear();
    send1(16'h7FFF);
    send1(16'h7FFF);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if (sat_flag !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid: sat=%b ov=%b, expected 0/0", sat_flag, out_valid);
    end
    feed4(16'd1, 16'd1, 16'd1, 16'd1, 0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'd4 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL clear_frame: ov=%b data=%h sat=%b, expected 1/0004/0",
               out_valid, data_out, sat_flag);
    end
    @(negedge clk);
    clear     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: ov=%b rdy=%b sat=%b, expected 0/1/0", out_valid, in_ready, sat_flag);
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    send1(16'h7FFF);
    send1(16'h7FFF);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sat_flag !== 1'b0 || out_valid !== 1'b0 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL areset_mid: sat=%b ov=%b data=%h, expected 0/0/0000", sat_flag, out_valid, data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    feed4(16'd1, 16'd2, 16'd3, 16'd4, 0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 16'd10 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL areset_after: ov=%b data=%h sat=%b, expected 1/000a/0",
               out_valid, data_out, sat_flag);
    end
    handshake();
    feed4(16'h7000, 16'h7000, 16'h7000, 16'h7000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 16'h0 || sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL areset_done: ov=%b data=%h sat=%b, expected 0/0000/0",
               out_valid, data_out, sat_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL areset_stale: stale out_valid seen=%b expected 0", seen);
    end
  endtask

  function automatic logic [15:0] rnd_sample();
    case ($urandom_range(0, 3))
      0: return 16'h7F00 | 16'($urandom_range(0, 255));
      1: return 16'h8000 | 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [15:0] v[4];
    logic [15:0] er;
    logic es;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 4; i++) v[i] = rnd_sample();
      model4(v[0], v[1], v[2], v[3], er, es);
      feed4(v[0], v[1], v[2], v[3], $urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || data_out !== er || sat_flag !== es) begin
        errors++;
        $display("FAIL random[%0d]: in=%h,%h,%h,%h ov=%b data=%h sat=%b, expected 1/%h/%b",
                 f, v[0], v[1], v[2], v[3], out_valid, data_out, sat_flag, er, es);
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate(16'h7000, 16'h7000, 16'h7000, 16'h7000, "pos_sat");
    test_saturate(16'h8000, 16'hFFFF, 16'h0000, 16'h0000, "neg_sat");
    test_saturate(16'h7FFF, 16'h0001, 16'h8001, 16'h0005, "sticky_nowrap");
    test_backpressure();
    test_gaps();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
